// File: rtl/cordic_seq_if.sv
// Bundle of the operand, stage-block and result channels of the CORDIC iteration sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface cordic_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic             in_mode_i;
  logic [WIDTH-1:0] in_x_i;
  logic [WIDTH-1:0] in_y_i;
  logic [WIDTH-1:0] in_z_i;

  logic             cs_mode_o;
  logic [4:0]       cs_stage_o;
  logic [WIDTH-1:0] cs_x_o;
  logic [WIDTH-1:0] cs_y_o;
  logic [WIDTH-1:0] cs_z_o;
  logic             cs_mode_i;
  logic [WIDTH-1:0] cs_x_i;
  logic [WIDTH-1:0] cs_y_i;
  logic [WIDTH-1:0] cs_z_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_mode_o;
  logic [WIDTH-1:0] out_x_o;
  logic [WIDTH-1:0] out_y_o;
  logic [WIDTH-1:0] out_z_o;

  logic             err_o;
  logic [1:0]       dbg_state_o;

  modport slave (
    input  in_valid_i, in_mode_i, in_x_i, in_y_i, in_z_i,
    output in_ready_o,
    output cs_mode_o, cs_stage_o, cs_x_o, cs_y_o, cs_z_o,
    input  cs_mode_i, cs_x_i, cs_y_i, cs_z_i,
    output out_valid_o, out_mode_o, out_x_o, out_y_o, out_z_o,
    input  out_ready_i,
    output err_o, dbg_state_o
  );

  modport master (
    output in_valid_i, in_mode_i, in_x_i, in_y_i, in_z_i,
    input  in_ready_o,
    input  cs_mode_o, cs_stage_o, cs_x_o, cs_y_o, cs_z_o,
    output cs_mode_i, cs_x_i, cs_y_i, cs_z_i,
    input  out_valid_o, out_mode_o, out_x_o, out_y_o, out_z_o,
    output out_ready_i,
    input  err_o, dbg_state_o
  );
endinterface

// File: rtl/cordic_seq.sv
// Iteration sequencer: runs one operand set through ITER passes of an external single-stage
// CORDIC block, feeding each stage result back, then presents the final vector.
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both 1;
// valid-side data is held stable until that edge, ready may be withdrawn at any time.
module cordic_seq #(
  parameter int WIDTH     = 32,
  parameter int ITER      = 24,
  parameter int STAGE_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  cordic_seq_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] LAST_K = 5'(ITER - 1);
  localparam logic [2:0] LAT    = 3'(STAGE_LAT);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic             mode_q, mode_d;
  logic [4:0]       k_q, k_d;
  logic [2:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic             ovalid_q, ovalid_d;
  logic             omode_q, omode_d;
  logic [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    mode_d   = mode_q;
    k_d      = k_q;
    wait_d   = wait_q;
    err_d    = err_q;
    ovalid_d = ovalid_q;
    omode_d  = omode_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    oz_d     = oz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          x_d     = bus.in_x_i;
          y_d     = bus.in_y_i;
          z_d     = bus.in_z_i;
          mode_d  = bus.in_mode_i;
          k_d     = 5'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          x_d = bus.cs_x_i;
          y_d = bus.cs_y_i;
          z_d = bus.cs_z_i;
          if (bus.cs_mode_i != mode_q) err_d = 1'b1;
          // Compare before increment so ITER = 32 finishes without k wrapping to 0.
          if (k_q == LAST_K) begin
            state_d  = S_DONE;
            ovalid_d = 1'b1;
            omode_d  = mode_q;
            ox_d     = bus.cs_x_i;
            oy_d     = bus.cs_y_i;
            oz_d     = bus.cs_z_i;
          end else begin
            k_d     = k_q + 5'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) begin
          state_d  = S_IDLE;
          ovalid_d = 1'b0;
          omode_d  = 1'b0;
          ox_d     = '0;
          oy_d     = '0;
          oz_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mode_q   <= 1'b0;
      k_q      <= 5'd0;
      wait_q   <= 3'd0;
      err_q    <= 1'b0;
      ovalid_q <= 1'b0;
      omode_q  <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      oz_q     <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      ovalid_q <= ovalid_d;
      omode_q  <= omode_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      oz_q     <= oz_d;
    end
  end

  // Working registers drive the stage block directly; they only move on capture, so they hold through WAIT.
  assign bus.cs_x_o      = x_q;
  assign bus.cs_y_o      = y_q;
  assign bus.cs_z_o      = z_q;
  assign bus.cs_mode_o   = mode_q;
  assign bus.cs_stage_o  = k_q;

  assign bus.in_ready_o  = (state_q == S_IDLE);
  assign bus.out_valid_o = ovalid_q;
  assign bus.out_mode_o  = omode_q;
  assign bus.out_x_o     = ox_q;
  assign bus.out_y_o     = oy_q;
  assign bus.out_z_o     = oz_q;
  assign bus.err_o       = err_q;
  assign bus.dbg_state_o = state_q;

endmodule
